uart_rx: RTL

Serial receive path for the UART: the counterpart of the transmit controller and shift register. It oversamples the `rx` line, detects and validates a start bit, samples each data bit at mid-bit, checks the stop bit, and presents the received byte on a valid/ready interface to the host side. Framing and overrun errors are reported as single-cycle pulses.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 16 +
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and default frame geometry.
// The transmit side uses the same defaults.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side byte handshake of the UART receiver.
// The receiver is the master; the host consumes bytes through the slave modport.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: pulses tick once every div+1 clocks.
// The tick is suppressed in the clear cycle so that the count restarts cleanly.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + DIV_W'(1);
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == div) begin
      tick  = 1'b1;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, samples start, data and stop bits at mid-bit,
// and hands completed bytes to the host with framing and overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  uart_rx_if.master        host,
  output logic             framing_err,
  output logic             overrun_err,
  output logic             busy
);

  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS + 1);
  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [DIV_W-1:0]     baud_div_q, baud_div_d;
  logic [SCNT_W-1:0]    scnt_q, scnt_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_err_q, overrun_err_d;

  logic tick;
  logic tick_clear;
  logic commit;
  logic frame_bad;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .div   (baud_div_q),
    .tick  (tick)
  );

  // Receive FSM: all sampling decisions happen on oversample ticks.
  always_comb begin
    state_d    = state_q;
    rx_meta_d  = rx;
    rx_s_d     = rx_meta_q;
    baud_div_d = baud_div_q;
    scnt_d     = scnt_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    tick_clear = 1'b0;
    commit     = 1'b0;
    frame_bad  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          baud_div_d = baud_div;
          tick_clear = 1'b1;
          scnt_d     = '0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          if (scnt_q == SCNT_HALF) begin
            if (!rx_s_q) begin
              scnt_d  = '0;
              bcnt_d  = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt_q == SCNT_LAST) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            scnt_d  = '0;
            bcnt_d  = bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_LAST) begin
              state_d = STOP;
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (scnt_q == SCNT_LAST) begin
            if (rx_s_q) begin
              commit  = 1'b1;
              state_d = IDLE;
            end else begin
              frame_bad = 1'b1;
              state_d   = BREAK;
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      BREAK: begin
        // Wait out a held-low line so it cannot look like a new start bit.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a commit wins over a simultaneous handshake.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    framing_err_d = frame_bad;
    overrun_err_d = 1'b0;
    if (rx_valid_q && host.rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (commit) begin
      if (!rx_valid_q || host.rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      baud_div_q    <= '0;
      scnt_q        <= '0;
      bcnt_q        <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      baud_div_q    <= baud_div_d;
      scnt_q        <= scnt_d;
      bcnt_q        <= bcnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;
  assign framing_err   = framing_err_q;
  assign overrun_err   = overrun_err_q;
  assign busy          = (state_q != IDLE);

endmodule
